index_decoder: RTL and testbench
================================

INDEX_DECODER -- requirements
Module: index_decoder

Interface
REQ-001 SHALL have parameter logS, default 4, giving the binary index width; S = 2**logS is the one-hot width.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port in_valid, input, 1 bit: index offered.
REQ-005 SHALL have port in_ready, output, 1 bit: index accepted this cycle when high together with in_valid.
REQ-006 SHALL have port in, input, logS bits: binary index to decode.
REQ-007 SHALL have port out_valid, output, 1 bit: out holds a decoded word.
REQ-008 SHALL have port out_ready, input, 1 bit: consumer takes out this cycle when high together with out_valid.
REQ-009 SHALL have port out, output, S bits: registered one-hot word, bit[in] set.
REQ-010 SHALL have port clear, input, 1 bit: synchronous clear of accumulated state.
REQ-011 SHALL have port mask, output, S bits: OR of all one-hot words accepted since reset or clear (DECODER_MASK_EN only).
REQ-012 SHALL have port count, output, logS+1 bits: number of set bits in mask (DECODER_MASK_EN only).
REQ-013 SHALL have port full, output, 1 bit: count == S (DECODER_MASK_EN only).
REQ-014 SHALL have port dup, output, 1 bit: one-cycle pulse, the index accepted last cycle was already set in mask (DECODER_MASK_EN only).

Function
REQ-015 SHALL make in_ready = !out_valid || out_ready (single output register, full throughput, combinational ready path).
REQ-016 SHALL, on acceptance, load out with 1<<in and set out_valid on the next edge (latency 1 cycle).
REQ-017 SHALL clear out_valid when out is taken and no new index is accepted the same cycle; out keeps its last value.
REQ-018 SHALL, on simultaneous take and accept, load the new word and keep out_valid high (no bubble).
REQ-019 SHALL hold out and out_valid stable while out_valid && !out_ready.
REQ-020 SHALL, on acceptance, OR the one-hot word into mask and increment count only if that bit was previously clear.
REQ-021 SHALL pulse dup for exactly one cycle after accepting an index whose bit was already set; mask and count unchanged.
REQ-022 SHALL, on clear without acceptance, zero mask, count and dup next edge; out and out_valid unaffected.
REQ-023 SHALL, on clear with simultaneous acceptance, leave mask = the new one-hot word, count = 1, dup = 0.
REQ-024 SHALL drive full combinationally from count; count never exceeds S.
REQ-025 SHALL ignore in when no acceptance occurs; in_valid may drop without acceptance.

Reset
REQ-026 SHALL, while rst_n is low, force out = 0, out_valid = 0, mask = 0, count = 0, dup = 0, independent of clk.
REQ-027 SHALL drive in_ready = 1 after reset; reset mid-transfer discards the held word.

Configuration
REQ-028 SHALL, with macro DECODER_MASK_EN defined, implement mask, count, full, dup per REQ-020..024.
REQ-029 SHALL, without DECODER_MASK_EN, tie mask, count, full, dup to 0, with no accumulation registers; the handshake datapath is identical in both builds.

Structure
REQ-030 SHALL place the stable-match width constants (logS default, S derivation) in the shared package stable_match_pkg.
REQ-031 SHALL use one combinational sub-module, onehot_decode (logS in, S out), instantiated once for the output word and mask update.

Verification
REQ-032 logS=4, in=5 accepted with out_ready=1 -> next cycle out=0x0020, out_valid=1, mask=0x0020, count=1.
REQ-033 out_ready=0, two indices offered (3, then 7) -> out stays 0x0008, in_ready=0 until take; then 0x0080 follows with no bubble.
REQ-034 Accept 2 then 2 -> dup pulses 1 cycle after second accept, count stays 1, mask=0x0004.
REQ-035 Accept all 16 indices 0..15 -> count=16, full=1, mask=0xFFFF; clear with simultaneous in=9 -> mask=0x0200, count=1, full=0.
REQ-036 rst_n low while out_valid=1 mid-stream -> out=0, out_valid=0, mask=0, count=0 immediately, without a clock edge; in_ready=1.
REQ-037 Build without DECODER_MASK_EN, repeat REQ-032/033 -> identical out/handshake timing, mask=count=full=dup=0 throughout.

Source files
------------

// File: rtl/stable_match_pkg.sv
// Shared width constants for the stable-match index/one-hot datapath.
// Contents:
//   LogSDefault   default binary index width
//   onehot_width  one-hot width S = 2**logS derived from an index width
package stable_match_pkg;

    localparam int unsigned LogSDefault = 4;

    function automatic int unsigned onehot_width(input int unsigned log_s);
        return 32'd1 << log_s;
    endfunction

endpackage

// File: rtl/onehot_decode.sv
// Combinational binary-to-one-hot decoder.
// Ports:
//   in   binary index, logS bits
//   out  one-hot word, S bits, bit[in] set
module onehot_decode
    import stable_match_pkg::*;
#(
    parameter  int unsigned logS = LogSDefault,
    localparam int unsigned S    = onehot_width(logS)
) (
    input  logic [logS-1:0] in,
    output logic [S-1:0]    out
);

    always_comb begin
        out     = '0;
        out[in] = 1'b1;
    end

endmodule

// File: rtl/index_decoder.sv
// Registered binary-to-one-hot decoder with a valid/ready handshake on both
// sides. A single output register gives full throughput; ready is
// combinational from the consumer side.
// Optional macro DECODER_MASK_EN adds an accumulation mask of every index
// accepted since reset/clear, its population count, a full flag and a
// duplicate pulse. Without it those outputs are tied to zero.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid/in_ready/in index input handshake and binary index
//   out_valid/out_ready  output handshake
//   out                  registered one-hot word
//   clear                synchronous clear of the accumulated state
//   mask, count, full    accumulated one-hot OR, its popcount, count == S
//   dup                  one-cycle pulse: last accepted index was already in mask
module index_decoder
    import stable_match_pkg::*;
#(
    parameter  int unsigned logS = LogSDefault,
    localparam int unsigned S    = onehot_width(logS)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [logS-1:0] in,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [S-1:0]    out,
    input  logic            clear,
    output logic [S-1:0]    mask,
    output logic [logS:0]   count,
    output logic            full,
    output logic            dup
);

    logic [S-1:0] dec;
    logic         accept;
    logic [S-1:0] out_q, out_d;
    logic         out_valid_q, out_valid_d;

    onehot_decode #(
        .logS(logS)
    ) u_onehot_decode (
        .in (in),
        .out(dec)
    );

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    always_comb begin
        out_d       = out_q;
        out_valid_d = out_valid_q;
        if (accept) begin
            out_d       = dec;
            out_valid_d = 1'b1;
        end else if (out_ready) begin
            // Word taken with nothing new behind it; out keeps its last value.
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;

`ifdef DECODER_MASK_EN
    logic [S-1:0] mask_q, mask_d;
    logic [logS:0] count_q, count_d;
    logic          dup_q, dup_d;
    logic          hit;

    assign hit = |(mask_q & dec);

    always_comb begin
        mask_d  = mask_q;
        count_d = count_q;
        dup_d   = 1'b0;
        if (clear) begin
            // A same-cycle acceptance seeds the freshly cleared mask.
            mask_d  = accept ? dec : '0;
            count_d = accept ? (logS+1)'(1) : '0;
        end else if (accept) begin
            mask_d = mask_q | dec;
            if (hit) begin
                dup_d = 1'b1;
            end else begin
                count_d = count_q + (logS+1)'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask_q  <= '0;
            count_q <= '0;
            dup_q   <= 1'b0;
        end else begin
            mask_q  <= mask_d;
            count_q <= count_d;
            dup_q   <= dup_d;
        end
    end

    assign mask  = mask_q;
    assign count = count_q;
    assign full  = (count_q == (logS+1)'(S));
    assign dup   = dup_q;
`else
    logic unused_clear;
    assign unused_clear = clear;

    assign mask  = '0;
    assign count = '0;
    assign full  = 1'b0;
    assign dup   = 1'b0;
`endif

endmodule

// File: tb/tb_index_decoder.sv
module tb_index_decoder;

    localparam int LOGS = 4;
    localparam int S    = 16;
`ifdef DECODER_MASK_EN
    localparam bit MaskEn = 1'b1;
`else
    localparam bit MaskEn = 1'b0;
`endif

    logic          clk       = 1'b0;
    logic          rst_n     = 1'b0;
    logic          in_valid  = 1'b0;
    logic          out_ready = 1'b0;
    logic          clear     = 1'b0;
    logic [LOGS-1:0] in_idx  = '0;
    logic          in_ready;
    logic          out_valid;
    logic [S-1:0]  out;
    logic [S-1:0]  mask;
    logic [LOGS:0] count;
    logic          full;
    logic          dup;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: set of indices seen, current held word, dup flag.
    bit          seen [S];
    bit          exp_valid = 1'b0;
    logic [31:0] exp_out   = 32'd0;
    bit          exp_dup   = 1'b0;

    index_decoder #(
        .logS(LOGS)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in       (in_idx),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out      (out),
        .clear    (clear),
        .mask     (mask),
        .count    (count),
        .full     (full),
        .dup      (dup)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int model_count();
        int c = 0;
        for (int i = 0; i < S; i++) c += seen[i] ? 1 : 0;
        return c;
    endfunction

    function automatic logic [31:0] model_mask();
        logic [31:0] m = 32'd0;
        for (int i = 0; i < S; i++) if (seen[i]) m += (32'd1 << i);
        return m;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < S; i++) seen[i] = 1'b0;
        exp_valid = 1'b0;
        exp_out   = 32'd0;
        exp_dup   = 1'b0;
    endtask

    task automatic check_outputs(input string tag);
        int c;
        c = model_count();
        check({tag, ".out"}, out, exp_out);
        check({tag, ".out_valid"}, out_valid, exp_valid);
        check({tag, ".mask"}, mask, MaskEn ? model_mask() : 32'd0);
        check({tag, ".count"}, count, MaskEn ? c : 0);
        check({tag, ".full"}, full, MaskEn && (c == S));
        check({tag, ".dup"}, dup, MaskEn && exp_dup);
    endtask

    // One clock cycle: drive at negedge, check ready, update model at the edge, check after.
    task automatic step(input bit v, input int idx, input bit ordy, input bit clr);
        bit accept;
        @(negedge clk);
        in_valid  = v;
        in_idx    = idx[LOGS-1:0];
        out_ready = ordy;
        clear     = clr;
        #1;
        check("in_ready", in_ready, !exp_valid || ordy);
        accept = v && (!exp_valid || ordy);
        @(posedge clk);
        if (accept) begin
            exp_out   = 32'd1 << idx;
            exp_valid = 1'b1;
        end else if (ordy) begin
            exp_valid = 1'b0;
        end
        if (clr) begin
            for (int i = 0; i < S; i++) seen[i] = 1'b0;
            exp_dup = 1'b0;
            if (accept) seen[idx] = 1'b1;
        end else if (accept) begin
            exp_dup   = seen[idx];
            seen[idx] = 1'b1;
        end else begin
            exp_dup = 1'b0;
        end
        #1;
        check_outputs("cyc");
    endtask

    initial begin
        model_reset();
        #3;
        check_outputs("reset");
        check("reset.in_ready", in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;

        // Single accept of index 5 with the consumer ready.
        step(1, 5, 1, 0);
        check("idx5.out", out, 32'h0020);
        check("idx5.mask", mask, MaskEn ? 32'h0020 : 32'h0);
        check("idx5.count", count, MaskEn ? 1 : 0);
        step(0, 0, 1, 0);

        // Backpressure: 3 accepted, 7 stalled, then take+accept with no bubble.
        step(1, 3, 0, 0);
        step(1, 7, 0, 0);
        step(1, 7, 0, 0);
        check("stall.out", out, 32'h0008);
        step(1, 7, 1, 0);
        check("nobubble.out", out, 32'h0080);
        check("nobubble.valid", out_valid, 1);
        step(0, 0, 1, 0);

        // Duplicate index.
        step(0, 0, 1, 1);
        step(1, 2, 1, 0);
        step(1, 2, 1, 0);
        check("dup.pulse", dup, MaskEn);
        check("dup.count", count, MaskEn ? 1 : 0);
        step(0, 0, 1, 0);
        check("dup.drop", dup, 0);

        // Fill all indices, then clear with simultaneous accept.
        step(0, 0, 1, 1);
        for (int i = 0; i < S; i++) step(1, i, 1, 0);
        check("fill.count", count, MaskEn ? 16 : 0);
        check("fill.full", full, MaskEn);
        step(1, 9, 1, 1);
        check("clracc.mask", mask, MaskEn ? 32'h0200 : 32'h0);
        check("clracc.full", full, 0);

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            step($urandom_range(0, 3) != 0, int'($urandom_range(0, S - 1)),
                 $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
        end

        // Asynchronous reset while a word is held.
        step(1, 11, 0, 0);
        step(0, 0, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs("areset");
        check("areset.in_ready", in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        step(1, 14, 1, 0);
        step(0, 0, 1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
